// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, key codes and matrix-to-code helpers for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} key_state_t;
  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_ZERO = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;
  // Digits 1-9 fill rows 0-2 left to right; row 3 holds *, 0, #.
  function automatic logic [3:0] rc_code(input logic [1:0] r, input logic [1:0] c);
    return r == 2'd3 ? (c == 2'd0 ? KEY_STAR : c == 2'd1 ? KEY_ZERO : KEY_HASH)
                     : {2'b0, r} * 4'd3 + {2'b0, c} + 4'd1;
  endfunction
  // A frame yields a code only when exactly one intersection is closed; ghosts and chords read as NONE.
  function automatic logic [3:0] frame_code(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
    logic [11:0] s;
    logic [3:0] code;
    s = {c2, c1, c0};
    code = KEY_NONE;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        if (s[4*c+r]) code = rc_code(2'(r), 2'(c));
    return $countones(s) == 1 ? code : KEY_NONE;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the debounced key stream toward the game-state block
interface keypad_scanner_if;
  logic       key_en;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_data;
  logic       key_valid;
  logic       key_held;
  modport master (output key_en, key_row, input key_col, key_data, key_valid, key_held);
  modport slave (input key_en, key_row, output key_col, key_data, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_scan_tick_gen.sv
// scan_tick_gen: column dwell counter with one-hot column rotation and end-of-frame pulse
module scan_tick_gen #(
  parameter int SCAN_DIV = 25000,
  parameter int CNT_W    = 15
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic       frame_done,
  output logic [2:0] col
);
  logic [CNT_W-1:0] cnt;
  assign tick = cnt == CNT_W'(SCAN_DIV - 1);
  assign frame_done = tick && col[2];
  // Advance the dwell counter; the last dwell cycle also steps the column drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      col <= 3'b001;
    end else if (tick) begin
      cnt <= '0;
      col <= {col[1:0], col[2]};
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans the 3x4 keypad, debounces whole frames and strobes one key code per press
module keypad_scanner import keypad_pkg::*; #(
  parameter int SCAN_DIV        = 25000,
  parameter int DEBOUNCE_FRAMES = 20,
  parameter int CNT_W           = 15
) (
  input logic clk,
  input logic rst,
  keypad_scanner_if.slave kp
);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  logic tick, frame_done, last, enter_press, enter_idle;
  logic [2:0] col;
  logic [3:0] s0, s1, frame_key, cand, press_key;
  logic [DW-1:0] cnt;
  key_state_t state;
  scan_tick_gen #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) u_tick (
    .clk(clk), .rst(rst), .tick(tick), .frame_done(frame_done), .col(col)
  );
  assign kp.key_col = col;
  // The third column is taken live on its tick, so the frame resolves in the same cycle.
  assign frame_key = frame_code(s0, s1, kp.key_row);
  assign last = int'(cnt) + 1 >= DEBOUNCE_FRAMES;
  assign enter_press = frame_done && frame_key != KEY_NONE &&
                       ((state == IDLE && DEBOUNCE_FRAMES == 1) || (state == CAND && frame_key == cand && last));
  assign enter_idle = frame_done && frame_key == KEY_NONE &&
                      ((state == PRESSED && DEBOUNCE_FRAMES == 1) || (state == REL && last));
  assign press_key = state == IDLE ? frame_key : cand;
  // Latch the first two column samples of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else if (tick) begin
      if (col[0]) s0 <= kp.key_row;
      if (col[1]) s1 <= kp.key_row;
    end
  end
  // Debounce state machine stepped once per frame, with registered key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cand         <= KEY_NONE;
      cnt          <= '0;
      kp.key_data  <= KEY_NONE;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      kp.key_valid <= 1'b0;
      if (enter_press) begin
        state       <= PRESSED;
        kp.key_held <= 1'b1;
        if (kp.key_en) begin
          kp.key_data  <= press_key;
          kp.key_valid <= 1'b1;
        end
      end else if (enter_idle) begin
        state       <= IDLE;
        kp.key_held <= 1'b0;
      end else if (frame_done) begin
        case (state)
          IDLE: if (frame_key != KEY_NONE) begin
            state <= CAND;
            cand  <= frame_key;
            cnt   <= DW'(1);
          end
          CAND: begin
            state <= frame_key == KEY_NONE ? IDLE : CAND;
            cand  <= frame_key == KEY_NONE ? cand : frame_key;
            cnt   <= frame_key == cand ? cnt + 1'b1 : DW'(1);
          end
          PRESSED: if (frame_key == KEY_NONE) begin
            state <= REL;
            cnt   <= DW'(1);
          end
          REL: begin
            state <= frame_key == KEY_NONE ? REL : PRESSED;
            cnt   <= cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed stimulus against a frame-level keypad reference model
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FR = 3 * SD;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] pressed = '0;
  int checks = 0;
  int errors = 0;
  int k, run_len, npulse;
  logic [11:0] seen;
  logic [3:0] run_key, m_data;
  logic m_held, m_valid;
  logic [2:0] m_col;
  keypad_scanner_if kp ();
  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF), .CNT_W(2)) dut (.clk(clk), .rst(rst), .kp(kp));
  always #5 clk = ~clk;
  // Physical keypad: a row reads high when a pressed key sits in a driven column.
  always_comb
    for (int r = 0; r < 4; r++) kp.key_row[r] = |(pressed[3*r +: 3] & kp.key_col);
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  // Reference: frames are sets of closed keys; a press is DF identical single-key frames while released,
  // a release is DF consecutive empty frames while held.
  task automatic model_step();
    int c, n, fk;
    if (rst) begin
      k = 0; seen = '0; run_key = '0; run_len = 0; m_held = 0; m_data = '0; m_valid = 0;
    end else begin
      m_valid = 0;
      c = (k / SD) % 3;
      if (k % SD == SD - 1) begin
        seen |= pressed & (12'h249 << c);
        if (c == 2) begin
          n = $countones(seen);
          fk = 0;
          for (int i = 0; i < 12; i++) if (n == 1 && seen[i]) fk = i + 1;
          seen = '0;
          if (fk == int'(run_key)) run_len++;
          else begin
            run_key = 4'(fk);
            run_len = 1;
          end
          if (!m_held && fk != 0 && run_len >= DF) begin
            m_held = 1;
            if (kp.key_en) begin
              m_data = 4'(fk);
              m_valid = 1;
            end
          end else if (m_held && fk == 0 && run_len >= DF) m_held = 0;
        end
      end
      k++;
    end
    m_col = 3'b001 << ((k / SD) % 3);
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      if (kp.key_valid === 1'b1) npulse++;
      chk("key_col", int'(kp.key_col), int'(m_col));
      chk("key_valid", int'(kp.key_valid), int'(m_valid));
      chk("key_held", int'(kp.key_held), int'(m_held));
      chk("key_data", int'(kp.key_data), int'(m_data));
    end
  endtask
  initial begin
    kp.key_en = 1'b1;
    cyc(3);
    rst = 1'b0;
    npulse = 0;
    cyc(100);
    chk("idle_pulses", npulse, 0);
    // key 5 held for 10 frames, then released
    npulse = 0;
    pressed = 12'b1 << 4;
    cyc(10 * FR);
    pressed = '0;
    cyc(5 * FR);
    chk("k5_pulses", npulse, 1);
    chk("k5_data", int'(kp.key_data), 5);
    // key 9 chattering, then stable
    npulse = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      pressed = ((i / 5) % 2 == 0) ? 12'b1 << 8 : '0;
      cyc();
    end
    chk("k9_chatter_pulses", npulse, 0);
    pressed = 12'b1 << 8;
    cyc(6 * FR);
    pressed = '0;
    cyc(5 * FR);
    chk("k9_pulses", npulse, 1);
    // key 1 bouncing during release, then a real re-press
    npulse = 0;
    pressed = 12'b1;
    cyc(5 * FR);
    pressed = '0;
    cyc(FR);
    pressed = 12'b1;
    cyc(3 * FR);
    pressed = '0;
    cyc(5 * FR);
    chk("k1_bounce_pulses", npulse, 1);
    pressed = 12'b1;
    cyc(5 * FR);
    pressed = '0;
    cyc(5 * FR);
    chk("k1_repress_pulses", npulse, 2);
    // ghost: keys 1 and 7 share column 0
    npulse = 0;
    pressed = 12'b1 | (12'b1 << 6);
    cyc(5 * FR);
    pressed = '0;
    cyc(2 * FR);
    chk("ghost_pulses", npulse, 0);
    pressed = 12'b1 << 11;
    cyc(5 * FR);
    pressed = '0;
    cyc(5 * FR);
    chk("hash_data", int'(kp.key_data), 12);
    // press consumed while disabled
    npulse = 0;
    kp.key_en = 1'b0;
    pressed = 12'b1 << 2;
    cyc(4 * FR);
    kp.key_en = 1'b1;
    cyc(3 * FR);
    pressed = '0;
    cyc(5 * FR);
    chk("disabled_pulses", npulse, 0);
    chk("disabled_data", int'(kp.key_data), 12);
    // reset during candidate debounce
    pressed = 12'b1 << 1;
    cyc(2 * FR);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    pressed = '0;
    cyc(5 * FR);
    // random segments: singles, chords, noise, enable changes, occasional reset
    for (int s = 0; s < 60; s++) begin
      int ch;
      ch = $urandom_range(0, 9);
      pressed = ch < 2 ? 12'h0 : ch < 8 ? 12'b1 << $urandom_range(0, 11) :
                ch == 8 ? (12'b1 << $urandom_range(0, 11)) | (12'b1 << $urandom_range(0, 11)) : 12'($urandom);
      kp.key_en = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 19) == 0;
      cyc();
      rst = 1'b0;
      cyc($urandom_range(1, 60));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
